// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned INST_W       = 32;
  localparam int unsigned FB_DEPTH_DEF = 2;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // Where the IF/ID register takes its next instruction from.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BUF  = 2'd1,
    SRC_BYP  = 2'd2
  } id_src_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, inst} FIFO holding fetched words while decode is stalled.
module fetch_buffer
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_W  = XLEN_DEF,
  parameter int unsigned DEPTH = FB_DEPTH_DEF,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [PC_W-1:0]   i_push_pc,
  input  logic [INST_W-1:0] i_push_inst,
  input  logic              i_pop,
  output logic [PC_W-1:0]   o_head_pc,
  output logic [INST_W-1:0] o_head_inst,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  // Pointers and occupancy; clear covers both reset and redirect.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_pc_mem[r_wr_ptr]   <= i_push_pc;
      r_inst_mem[r_wr_ptr] <= i_push_inst;
    end
  end

  assign o_head_pc   = r_pc_mem[r_rd_ptr];
  assign o_head_inst = r_inst_mem[r_rd_ptr];
  assign o_count     = r_count;

  // The issue credit keeps pushes away from a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (i_clear)
    !(i_push && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, credit-based IMEM issue, redirect kill and IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned     FB_DEPTH = FB_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IF_ID_w,
  input  logic              Branch_Taken,
  input  logic [XLEN-1:0]   Branch_Target,
  output logic              Imem_Req,
  output logic [XLEN-1:0]   Imem_Addr,
  input  logic [INST_W-1:0] Imem_Rdata,
  output logic [XLEN-1:0]   ID_Pc,
  output logic [INST_W-1:0] ID_Inst,
  output logic              ID_Valid
);

  localparam int unsigned CNT_W = $clog2(FB_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [XLEN-1:0]   r_pc;
  logic              r_inflight;
  logic [XLEN-1:0]   r_inflight_pc;
  logic              r_kill;
  logic [XLEN-1:0]   r_id_pc;
  logic [INST_W-1:0] r_id_inst;
  logic              r_id_valid;

  logic              w_flush;
  logic              w_resp_vld;
  logic [XLEN-1:0]   w_target;
  id_src_e           w_id_src;
  logic              w_pop;
  logic              w_bypass;
  logic              w_push;
  logic              w_issue;
  logic [OCC_W-1:0]  w_occ;
  logic [OCC_W-1:0]  w_credit_lim;
  logic [CNT_W-1:0]  w_fb_count;
  logic [XLEN-1:0]   w_head_pc;
  logic [INST_W-1:0] w_head_inst;

  assign w_flush    = rst || Branch_Taken;
  assign w_resp_vld = r_inflight && !r_kill;
  assign w_target   = Branch_Target & ~XLEN'(3);

  // IF/ID source: buffered words are older than the arriving response.
  always_comb begin
    w_id_src = SRC_NONE;
    if (!w_flush && IF_ID_w) begin
      if (w_fb_count != '0) begin
        w_id_src = SRC_BUF;
      end else if (w_resp_vld) begin
        w_id_src = SRC_BYP;
      end
    end
  end

  assign w_pop    = (w_id_src == SRC_BUF);
  assign w_bypass = (w_id_src == SRC_BYP);
  assign w_push   = !w_flush && w_resp_vld && !w_bypass;

  // Issue only while buffered + in-flight words, net of this cycle's pop, stay below depth.
  assign w_occ        = OCC_W'(w_fb_count) + OCC_W'(w_resp_vld);
  assign w_credit_lim = OCC_W'(FB_DEPTH) + OCC_W'(w_pop);
  assign w_issue      = !w_flush && (w_occ < w_credit_lim);

  assign Imem_Req  = w_issue;
  assign Imem_Addr = r_pc;

  fetch_buffer #(
    .PC_W  (XLEN),
    .DEPTH (FB_DEPTH)
  ) u_fetch_buffer (
    .clk         (clk),
    .i_clear     (w_flush),
    .i_push      (w_push),
    .i_push_pc   (r_inflight_pc),
    .i_push_inst (Imem_Rdata),
    .i_pop       (w_pop),
    .o_head_pc   (w_head_pc),
    .o_head_inst (w_head_inst),
    .o_count     (w_fb_count)
  );

  // PC, in-flight tracking and the one-cycle kill after a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
      r_kill        <= 1'b0;
    end else begin
      r_kill     <= Branch_Taken;
      r_inflight <= w_issue;
      if (Branch_Taken) begin
        r_pc <= w_target;
      end else if (w_issue) begin
        r_pc          <= r_pc + XLEN'(4);
        r_inflight_pc <= r_pc;
      end
    end
  end

  // IF/ID pipeline register; holds on stall, bubbles on flush or starvation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pc    <= '0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (Branch_Taken) begin
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (IF_ID_w) begin
      case (w_id_src)
        SRC_BUF: begin
          r_id_pc    <= w_head_pc;
          r_id_inst  <= w_head_inst;
          r_id_valid <= 1'b1;
        end
        SRC_BYP: begin
          r_id_pc    <= r_inflight_pc;
          r_id_inst  <= Imem_Rdata;
          r_id_valid <= 1'b1;
        end
        default: begin
          r_id_inst  <= NOP_INST;
          r_id_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ID_Pc    = r_id_pc;
  assign ID_Inst  = r_id_inst;
  assign ID_Valid = r_id_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage with an IMEM that returns its address as data.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        IF_ID_w;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Rdata;
  logic [31:0] ID_Pc;
  logic [31:0] ID_Inst;
  logic        ID_Valid;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .IF_ID_w       (IF_ID_w),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Imem_Req      (Imem_Req),
    .Imem_Addr     (Imem_Addr),
    .Imem_Rdata    (Imem_Rdata),
    .ID_Pc         (ID_Pc),
    .ID_Inst       (ID_Inst),
    .ID_Valid      (ID_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency IMEM returning the word address as the instruction.
  initial Imem_Rdata = 32'h0;
  always @(posedge clk) if (Imem_Req) Imem_Rdata <= Imem_Addr;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endfunction

  // Drive one cycle's inputs just after the edge and let combinational outputs settle.
  task automatic drive(input logic r, input logic w, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst           = r;
    IF_ID_w       = w;
    Branch_Taken  = b;
    Branch_Target = t;
    #1;
  endtask

  // Reset, stream six words, then stall until the buffer is full (ID holds 0x10).
  task automatic prime_full();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("full_req_low", 32'(Imem_Req), 32'h0);
    chk("full_id_hold", ID_Pc, 32'h10);
  endtask

  task automatic redirect_case(input string tag, input logic w_in_br, input logic [31:0] tgt);
    logic [31:0] a;
    logic [31:0] a4;
    logic [31:0] a8;
    a  = tgt & 32'hFFFF_FFFC;
    a4 = a + 32'd4;
    a8 = a + 32'd8;
    prime_full();
    drive(1'b0, w_in_br, 1'b1, tgt);
    chk({tag, "_R_req"}, 32'(Imem_Req), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk({tag, "_R1_valid"}, 32'(ID_Valid), 32'h0);
    chk({tag, "_R1_inst"}, ID_Inst, NOP);
    chk({tag, "_R1_req"}, 32'(Imem_Req), 32'h1);
    chk({tag, "_R1_addr"}, Imem_Addr, a);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk({tag, "_R2_valid"}, 32'(ID_Valid), 32'h0);
    chk({tag, "_R2_addr"}, Imem_Addr, a4);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk({tag, "_R3_valid"}, 32'(ID_Valid), 32'h1);
    chk({tag, "_R3_pc"}, ID_Pc, a);
    chk({tag, "_R3_inst"}, ID_Inst, a);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk({tag, "_R4_pc"}, ID_Pc, a4);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk({tag, "_R5_pc"}, ID_Pc, a8);
  endtask

  typedef struct {
    logic        rst;
    logic        w;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] exp_q [$];
  logic [31:0] next_exp;
  logic [31:0] e;
  logic        w_now;
  logic        prev_w;

  initial begin
    rst = 1'b1; IF_ID_w = 1'b1; Branch_Taken = 1'b0; Branch_Target = 32'h0;

    // Reset, start-up and a four-cycle stall at ID_Pc = 0x8.
    vecs = '{
      '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00},
      '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00},
      '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00},
      '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00},
      '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00},
      '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00},
      '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04},
      '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08},
      '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08},
      '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08},
      '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08},
      '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08},
      '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C},
      '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10},
      '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14},
      '{1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18}
    };

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].w, 1'b0, 32'h0);
      chk($sformatf("vec%0d_req", i), 32'(Imem_Req), 32'(vecs[i].req));
      if (vecs[i].req || vecs[i].rst)
        chk($sformatf("vec%0d_addr", i), Imem_Addr, vecs[i].addr);
      chk($sformatf("vec%0d_valid", i), 32'(ID_Valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_inst", i), ID_Inst, vecs[i].valid ? vecs[i].pc : NOP);
      if (vecs[i].valid || vecs[i].rst)
        chk($sformatf("vec%0d_pc", i), ID_Pc, vecs[i].pc);
    end

    // Streaming with random stalls: each enabled cycle owes the next sequential word.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    exp_q.delete();
    next_exp = 32'h0;
    prev_w   = 1'b1;
    for (int k = 0; k < 60; k++) begin
      w_now = (k < 14) ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive(1'b0, w_now, 1'b0, 32'h0);
      if (k < 2) begin
        chk("stream_prime_valid", 32'(ID_Valid), 32'h0);
      end else if (prev_w) begin
        chk("stream_valid", 32'(ID_Valid), 32'h1);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL stream_queue: got empty scoreboard, required a pending word");
        end else begin
          e = exp_q.pop_front();
          chk("stream_pc", ID_Pc, e);
          chk("stream_inst", ID_Inst, e);
        end
      end
      if (k >= 1 && w_now) begin
        exp_q.push_back(next_exp);
        next_exp = next_exp + 32'd4;
      end
      prev_w = w_now;
    end

    // Redirects from a full buffer, with and without a simultaneous stall, plus address wrap.
    redirect_case("br_full", 1'b1, 32'h0000_0100);
    redirect_case("br_stall", 1'b0, 32'h0000_0200);
    redirect_case("br_wrap", 1'b1, 32'hFFFF_FFFE);

    // Reset pulse during a full-buffer stall.
    prime_full();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rstpulse_req", 32'(Imem_Req), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rstpulse_k0_addr", Imem_Addr, 32'h0);
    chk("rstpulse_k0_req", 32'(Imem_Req), 32'h1);
    chk("rstpulse_k0_valid", 32'(ID_Valid), 32'h0);
    chk("rstpulse_k0_inst", ID_Inst, NOP);
    chk("rstpulse_k0_pc", ID_Pc, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rstpulse_k1_valid", 32'(ID_Valid), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rstpulse_k2_valid", 32'(ID_Valid), 32'h1);
    chk("rstpulse_k2_pc", ID_Pc, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rstpulse_k3_pc", ID_Pc, 32'h4);
    chk("rstpulse_k3_inst", ID_Inst, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
